// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: a single full-adder cell consumes one operand
// bit per clock, LSB first, and shifts the result in from the MSB end.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic w_accept;
  logic w_last;
  logic w_abit;
  logic w_bbit;
  logic w_sbit;
  logic w_cnext;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_abit   = r_a[r_cnt];
  assign w_bbit   = r_b[r_cnt];
  assign w_sbit   = w_abit ^ w_bbit ^ r_carry;
  assign w_cnext  = (w_abit & w_bbit) | (r_carry & (w_abit ^ w_bbit));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, so the inversion and the +1 are folded into the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= {w_sbit, r_sum[WIDTH-1:1]};
      r_carry <= w_cnext;
      if (w_last) begin
        r_cnt  <= '0;
        r_cout <= w_cnext;
        r_ovf  <= r_carry ^ w_cnext;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range is WIDTH >= 2.
REQ-002 Port: clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 Port: rst, input, 1, reset; asynchronous and active-high.
REQ-004 Port: start, input, 1, request to begin an operation; sampled on the rising edge of clk.
REQ-005 Port: sub, input, 1, mode select (0 = a+b+cin, 1 = a-b); sampled with start.
REQ-006 Port: a, input, WIDTH, first operand; sampled with start.
REQ-007 Port: b, input, WIDTH, second operand; sampled with start.
REQ-008 Port: cin, input, 1, carry-in for add mode; sampled with start; ignored when sub=1.
REQ-009 Port: sum, output, WIDTH, result.
REQ-010 Port: cout, output, 1, carry-out in add mode; no-borrow flag in sub mode (1 when a >= b unsigned).
REQ-011 Port: ovf, output, 1, two's-complement overflow.
REQ-012 Port: busy, output, 1, high while an operation is in progress.
REQ-013 Port: done, output, 1, one-cycle pulse marking a valid result.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-015 IDLE transitions: start=1 -> RUN; otherwise stay in IDLE.
REQ-016 RUN transitions: stay in RUN for exactly WIDTH cycles, then go to DONE.
REQ-017 DONE transitions: start=1 -> RUN (back-to-back operation); otherwise -> IDLE.
REQ-018 DONE SHALL last exactly one cycle.
REQ-019 On an accepted start, the block SHALL latch the following in one edge:
- a;
- b, or ~b when sub=1;
- carry = cin when sub=0, or 1 when sub=1;
- bit counter cleared to 0.
REQ-020 start SHALL be accepted only in IDLE or DONE.
REQ-021 start asserted in RUN SHALL be ignored, and the latched operands SHALL be unaffected.
REQ-022 Each RUN cycle SHALL process one bit, LSB first, using a one-bit full-adder cell on (a[i], b'[i], carry):
- the sum bit is shifted into the MSB of the result shift register;
- carry is updated;
- the counter is incremented.
REQ-023 The counter SHALL be $clog2(WIDTH) bits wide.
REQ-024 After the final bit (counter = WIDTH-1), the counter SHALL wrap to 0 and the FSM SHALL enter DONE.
REQ-025 Latency: with start sampled at edge 0, bit i SHALL be computed at edge i+1, and done=1 SHALL hold from edge WIDTH until edge WIDTH+1.
REQ-026 When done rises, the outputs SHALL be:
- cout = final carry;
- ovf = (carry into the MSB) XOR (carry out of the MSB);
- sum = the full WIDTH-bit result.
REQ-027 sum, cout and ovf SHALL be valid from the cycle done=1 until the next accepted start.
REQ-028 sum SHALL be undefined-as-result, but deterministic, while busy=1.
REQ-029 busy SHALL equal 1 exactly in RUN.
REQ-030 done SHALL equal 1 exactly in DONE.
REQ-031 busy and done SHALL never be high together.
REQ-032 Add mode SHALL wrap modulo 2^WIDTH, with the carry reported on cout.
REQ-033 Sub mode SHALL compute a + ~b + 1 modulo 2^WIDTH.

Reset
REQ-034 rst=1 SHALL immediately, without waiting for clk, force:
- state = IDLE;
- counter = 0;
- carry = 0;
- sum = 0, cout = 0, ovf = 0;
- busy = 0, done = 0.
REQ-035 Reset asserted mid-operation SHALL abort the operation, and no done pulse SHALL be generated for it.
REQ-036 The first start after rst deasserts SHALL be accepted normally.
REQ-037 start sampled while rst=1 SHALL be ignored.

Verification (WIDTH=8)
REQ-038 Add with signed overflow: a=0x5A, b=0x33, cin=0, sub=0 -> sum=0x8D, cout=0, ovf=1; busy high for 8 cycles, then done high for 1 cycle.
REQ-039 Add carry-out and carry-in cases:
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0;
- a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-040 Subtract cases:
- sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0;
- sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-041 Ignored start during RUN: start with a=0x01, b=0x02; on RUN cycle 3 pulse start with a=0xAA, b=0x55 -> result sum=0x03; exactly one done pulse.
REQ-042 Back-to-back: start held high in the DONE cycle with new operands a=0x0F, b=0x01 -> first result presented, RUN re-entered the next cycle, second done shows sum=0x10.
REQ-043 Reset mid-run: assert rst asynchronously on RUN cycle 4 -> busy, done and sum go to 0 before the next edge, with no done pulse; after release, a=0x03, b=0x04 -> sum=0x07.
